hazard_ctrl: RTL and testbench

Pipeline hazard and flush controller for the 5-stage MIPS core. It generates the `write` and flush controls consumed by the IF/ID, ID/EXE and EXE/MEM pipeline registers and the PC. It detects load-use hazards between the ID and EXE stages and inserts one bubble. It flushes younger instructions on a branch taken in MEM, and freezes the whole pipeline while data memory is busy. Saturating stall and flush counters are exposed for debug.

---
 rtl/hazard_ctrl_pkg.sv | 24 ++
 rtl/hazard_ctrl_sat_counter.sv | 31 +++
 rtl/hazard_ctrl.sv | 96 +++++++++
 tb/tb_hazard_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/flush controller.
package hazard_ctrl_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned REG_W     = 5;

  typedef enum logic [1:0] {
    HC_RUN   = 2'd0,
    HC_STALL = 2'd1,
    HC_FLUSH = 2'd2,
    HC_RSVD  = 2'd3
  } hc_state_e;

  // Pipeline register controls, bundled so the decode assigns them as one unit.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_exe_write;
    logic id_exe_flush;
    logic exe_mem_flush;
  } hc_ctl_t;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall, branch flush and memory-wait freeze controller for the
// 5-stage pipeline; controls are a zero-latency Mealy decode of state and inputs.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] idRs,
  input  logic [REG_W-1:0] idRt,
  input  logic             idUsesRt,
  input  logic [REG_W-1:0] exeRt,
  input  logic             exeMemToReg,
  input  logic             exeRegWrite,
  input  logic             memBranchTaken,
  input  logic             memWait,
  output logic             pcWrite,
  output logic             ifIdWrite,
  output logic             ifIdFlush,
  output logic             idExeWrite,
  output logic             idExeFlush,
  output logic             exeMemFlush,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount,
  output logic [1:0]       state
);

  hc_state_e state_q;
  hc_state_e state_d;
  hc_ctl_t   ctl;
  logic      hz;
  logic      stall_inc;
  logic      flush_inc;

  assign hz = exeMemToReg && exeRegWrite && (exeRt != '0) &&
              ((exeRt == idRs) || (idUsesRt && (exeRt == idRt)));

  // Reset forces every enable low combinationally so the pipeline freezes at once.
  always_comb begin
    state_d   = state_q;
    ctl       = '0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (!reset) begin
      state_d = HC_RUN;
    end else if (memWait) begin
      state_d = state_q;
    end else if (memBranchTaken) begin
      ctl       = '1;
      state_d   = HC_FLUSH;
      flush_inc = 1'b1;
    end else if ((state_q == HC_RUN) && hz) begin
      ctl.id_exe_write = 1'b1;
      ctl.id_exe_flush = 1'b1;
      state_d          = HC_STALL;
      stall_inc        = 1'b1;
    end else begin
      ctl.pc_write     = 1'b1;
      ctl.if_id_write  = 1'b1;
      ctl.id_exe_write = 1'b1;
      state_d          = HC_RUN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HC_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk    (clk),
    .rst_n  (reset),
    .en_i   (stall_inc),
    .count_o(stallCount)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk    (clk),
    .rst_n  (reset),
    .en_i   (flush_inc),
    .count_o(flushCount)
  );

  assign pcWrite     = ctl.pc_write;
  assign ifIdWrite   = ctl.if_id_write;
  assign ifIdFlush   = ctl.if_id_flush;
  assign idExeWrite  = ctl.id_exe_write;
  assign idExeFlush  = ctl.id_exe_flush;
  assign exeMemFlush = ctl.exe_mem_flush;
  assign state       = 2'(state_q);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a reference model pushes the expected
// controls/state/counters when inputs are driven; they are popped at the negedge.
module tb_hazard_ctrl;

  localparam int unsigned CW  = 4;
  localparam int          MAX = 15;

  logic          clk;
  logic          reset;
  logic [4:0]    idRs, idRt, exeRt;
  logic          idUsesRt, exeMemToReg, exeRegWrite, memBranchTaken, memWait;
  logic          pcWrite, ifIdWrite, ifIdFlush, idExeWrite, idExeFlush, exeMemFlush;
  logic [CW-1:0] stallCount, flushCount;
  logic [1:0]    state;

  typedef struct {
    logic [5:0] ctl;
    int         st;
    int         sc;
    int         fc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_st = 0, m_sc = 0, m_fc = 0;

  hazard_ctrl #(.CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .idRs          (idRs),
    .idRt          (idRt),
    .idUsesRt      (idUsesRt),
    .exeRt         (exeRt),
    .exeMemToReg   (exeMemToReg),
    .exeRegWrite   (exeRegWrite),
    .memBranchTaken(memBranchTaken),
    .memWait       (memWait),
    .pcWrite       (pcWrite),
    .ifIdWrite     (ifIdWrite),
    .ifIdFlush     (ifIdFlush),
    .idExeWrite    (idExeWrite),
    .idExeFlush    (idExeFlush),
    .exeMemFlush   (exeMemFlush),
    .stallCount    (stallCount),
    .flushCount    (flushCount),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] dut_ctl();
    return {pcWrite, ifIdWrite, ifIdFlush, idExeWrite, idExeFlush, exeMemFlush};
  endfunction

  // One clock: drive at posedge+1, push model prediction, compare at negedge.
  task automatic step(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                      input logic usesRt, input logic [4:0] ert, input logic m2r,
                      input logic rw, input logic br, input logic mw);
    exp_t e;
    exp_t o;
    logic hzm;
    int   nst, nsc, nfc;
    idRs = rs; idRt = rt; idUsesRt = usesRt; exeRt = ert;
    exeMemToReg = m2r; exeRegWrite = rw; memBranchTaken = br; memWait = mw;
    hzm = m2r && rw && (ert != 0) && ((ert == rs) || (usesRt && (ert == rt)));
    nst = m_st; nsc = m_sc; nfc = m_fc;
    if (mw) begin
      e.ctl = 6'b000000;
    end else if (br) begin
      e.ctl = 6'b111111;
      nst = 2;
      nfc = (m_fc < MAX) ? m_fc + 1 : MAX;
    end else if (m_st == 0 && hzm) begin
      e.ctl = 6'b000110;
      nst = 1;
      nsc = (m_sc < MAX) ? m_sc + 1 : MAX;
    end else begin
      e.ctl = 6'b110100;
      nst = 0;
    end
    e.st = m_st; e.sc = m_sc; e.fc = m_fc;
    q.push_back(e);
    @(negedge clk);
    o = q.pop_front();
    chk({tag, ".ctl"},   32'(dut_ctl()),  32'(o.ctl));
    chk({tag, ".state"}, 32'(state),      32'(o.st));
    chk({tag, ".stall"}, 32'(stallCount), 32'(o.sc));
    chk({tag, ".flush"}, 32'(flushCount), 32'(o.fc));
    m_st = nst; m_sc = nsc; m_fc = nfc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    idRs = '0; idRt = '0; idUsesRt = 1'b0; exeRt = '0;
    exeMemToReg = 1'b0; exeRegWrite = 1'b0; memBranchTaken = 1'b0; memWait = 1'b0;
    #3;
    chk("rst.ctl",   32'(dut_ctl()),  32'h0);
    chk("rst.state", 32'(state),      32'h0);
    chk("rst.stall", 32'(stallCount), 32'h0);
    chk("rst.flush", 32'(flushCount), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    step("idle", 0, 0, 0, 0, 0, 0, 0, 0);
    // Load-use on rs: bubble, STALL, then back to RUN.
    step("lu_rs", 5, 0, 0, 5, 1, 1, 0, 0);
    step("lu_rs_stall", 5, 0, 0, 5, 1, 1, 0, 0);
    step("lu_rs_after", 1, 2, 0, 3, 0, 0, 0, 0);
    chk("lu_rs.cnt", 32'(stallCount), 32'd1);
    // Register zero and rt-not-read cases never stall.
    step("r0", 0, 0, 1, 0, 1, 1, 0, 0);
    step("rt_unused", 1, 7, 0, 7, 1, 1, 0, 0);
    step("rt_used", 1, 7, 1, 7, 1, 1, 0, 0);
    step("rt_used_st", 1, 7, 1, 7, 1, 1, 0, 0);
    step("no_regwrite", 5, 0, 0, 5, 1, 0, 0, 0);
    // Branch taken beats a simultaneous hazard.
    step("br_hz", 5, 0, 0, 5, 1, 1, 1, 0);
    chk("br_hz.state", 32'(state), 32'd2);
    chk("br_hz.flush", 32'(flushCount), 32'd1);
    step("br_after", 0, 0, 0, 0, 0, 0, 0, 0);
    // memWait holds everything, then the hazard applies when it falls.
    for (int i = 0; i < 4; i++) step("mw_hz", 9, 0, 0, 9, 1, 1, 0, 1);
    step("mw_fall", 9, 0, 0, 9, 1, 1, 0, 0);
    chk("mw_fall.state", 32'(state), 32'd1);
    step("mw_st", 0, 0, 0, 0, 0, 0, 0, 1);
    step("mw_st_rel", 0, 0, 0, 0, 0, 0, 0, 0);
    step("br_mw", 0, 0, 0, 0, 0, 0, 1, 1);
    // Saturation: 19 more stall events with a persistent hazard.
    for (int i = 0; i < 38; i++) step("sat", 3, 0, 0, 3, 1, 1, 0, 0);
    step("sat_end", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("sat.cnt", 32'(stallCount), 32'd15);
    // Asynchronous reset in the middle of FLUSH.
    step("br2", 0, 0, 0, 0, 0, 0, 1, 0);
    chk("br2.state", 32'(state), 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst.state", 32'(state),      32'h0);
    chk("mid_rst.stall", 32'(stallCount), 32'h0);
    chk("mid_rst.flush", 32'(flushCount), 32'h0);
    chk("mid_rst.ctl",   32'(dut_ctl()),  32'h0);
    m_st = 0; m_sc = 0; m_fc = 0;
    @(posedge clk);
    #1;
    chk("mid_rst_hold.ctl", 32'(dut_ctl()), 32'h0);
    reset = 1'b1;
    step("post_rst", 4, 0, 0, 4, 1, 1, 0, 0);
    step("post_rst2", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("sb_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
